b10_stim_sequencer: RTL and testbench

Programmable opcode sequencer that drives the b10 voting-controller inputs from an internal 12-bit opcode store. Replays one opcode per clock, stalls on request-to-send opcodes until the DUT answers with `cts`, and flags a handshake timeout. It sits beside the b10 instance in the conquest test harness. The harness can load a sequence once, run it with a `go` pulse, and read `done` and `pc` instead of relying on a free-running program counter.

---
 rtl/b10_stim_sequencer_if.sv | 30 +++
 rtl/b10_stim_sequencer.sv | 92 +++++++++
 tb/tb_b10_stim_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/b10_stim_sequencer_if.sv
// b10_stim_sequencer_if: config, run-control and b10 drive signals of the opcode sequencer
interface b10_stim_sequencer_if #(
  parameter int AW = 3
);
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [11:0] cfg_data;
  logic [AW:0] len;
  logic go;
  logic cts_i;
  logic ctr_i;
  logic r_button_o, g_button_o, key_o, start_o, test_o, rts_o, rtr_o;
  logic [3:0] v_in_o;
  logic obs_o;
  logic busy;
  logic done;
  logic timeout_err;
  logic ctr_seen;
  logic [AW-1:0] pc;
  modport master (
    output cfg_we, cfg_addr, cfg_data, len, go, cts_i, ctr_i,
    input r_button_o, g_button_o, key_o, start_o, test_o, rts_o, rtr_o, v_in_o, obs_o,
    input busy, done, timeout_err, ctr_seen, pc
  );
  modport slave (
    input cfg_we, cfg_addr, cfg_data, len, go, cts_i, ctr_i,
    output r_button_o, g_button_o, key_o, start_o, test_o, rts_o, rtr_o, v_in_o, obs_o,
    output busy, done, timeout_err, ctr_seen, pc
  );
endinterface

// File: rtl/b10_stim_sequencer.sv
// b10_stim_sequencer: replays a loaded opcode store into b10, stalling on rts until cts.
// Define B10_SEQ_TIMEOUT_EN to add the handshake wait counter and ERR timeout.
module b10_stim_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int TIMEOUT = 15
) (
  input logic clock,
  input logic reset,
  b10_stim_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  state_t state, state_d;
  logic [11:0] store [DEPTH];
  logic [11:0] op_q, op_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d;
  logic terr_q, terr_d, ctr_q, ctr_d;
  logic start, stall, last, expire;
  always_ff @(posedge clock)
    if (bus.cfg_we && state != RUN) store[bus.cfg_addr] <= bus.cfg_data;
  assign start = bus.go && (state == IDLE || state == ERR);
  assign stall = op_q[5] && !bus.cts_i;
  assign last = len_q == {1'b0, pc_q} + (AW+1)'(1);
`ifdef B10_SEQ_TIMEOUT_EN
  logic [7:0] wait_q;
  assign expire = stall && wait_q == 8'(TIMEOUT - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) wait_q <= '0;
    else wait_q <= (state == RUN && stall) ? wait_q + 8'd1 : '0;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign expire = 1'b0;
`endif
  // op_q is zeroed whenever RUN is left, so it can drive the b10 pins directly
  always_comb begin
    state_d = state;
    pc_d = pc_q;
    op_d = op_q;
    len_d = len_q;
    terr_d = terr_q;
    ctr_d = ctr_q;
    if (start && bus.len != '0) begin
      state_d = RUN;
      pc_d = '0;
      op_d = store[0];
      len_d = bus.len;
      terr_d = 1'b0;
      ctr_d = 1'b0;
    end else if (start) begin
      state_d = DONE;
      op_d = '0;
    end else if (state == RUN) begin
      ctr_d = ctr_q | bus.ctr_i;
      if (expire) begin
        state_d = ERR;
        op_d = '0;
        terr_d = 1'b1;
      end else if (!stall && last) begin
        state_d = DONE;
        op_d = '0;
      end else if (!stall) begin
        pc_d = pc_q + AW'(1);
        op_d = store[pc_q + AW'(1)];
      end
    end else if (state == DONE) state_d = IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pc_q <= '0;
      op_q <= '0;
      len_q <= '0;
      terr_q <= 1'b0;
      ctr_q <= 1'b0;
    end else begin
      state <= state_d;
      pc_q <= pc_d;
      op_q <= op_d;
      len_q <= len_d;
      terr_q <= terr_d;
      ctr_q <= ctr_d;
    end
  assign {bus.obs_o, bus.v_in_o, bus.rtr_o, bus.rts_o, bus.test_o, bus.start_o, bus.key_o,
          bus.g_button_o, bus.r_button_o} = op_q;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.timeout_err = terr_q;
  assign bus.ctr_seen = ctr_q;
  assign bus.pc = pc_q;
endmodule

// File: tb/tb_b10_stim_sequencer.sv
// tb_b10_stim_sequencer: random and directed runs checked cycle by cycle against a trace-level model
module tb_b10_stim_sequencer;
  localparam int AW = 3;
  localparam int TO = 15;
  localparam int MAXC = 400;
`ifdef B10_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  b10_stim_sequencer_if #(.AW(AW)) bus ();
  b10_stim_sequencer #(.DEPTH(8), .AW(AW), .TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [11:0] m_store [8];
  bit terr_m, ctr_m;
  bit cts [MAXC];
  bit ctr [MAXC];
  bit wr_en [MAXC];
  logic [2:0] wr_addr [MAXC];
  logic [11:0] wr_data [MAXC];
  logic [11:0] exp_op [MAXC];
  logic [2:0] exp_pc [MAXC];
  bit exp_busy [MAXC], exp_done [MAXC], exp_terr [MAXC], exp_ctr [MAXC];
  logic [11:0] obs_op [MAXC];
  logic [2:0] obs_pc [MAXC];
  bit obs_busy [MAXC], obs_done [MAXC], obs_terr [MAXC];
  int ncyc, cyc;
  bit active = 1'b0;
  function automatic void chk(string nm, int c, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", nm, c, a, e);
    end
  endfunction
  function automatic logic [11:0] dut_op();
    return {bus.obs_o, bus.v_in_o, bus.rtr_o, bus.rts_o, bus.test_o, bus.start_o, bus.key_o,
            bus.g_button_o, bus.r_button_o};
  endfunction
  function automatic void put(logic [11:0] op, int pc, bit busy, bit done);
    exp_op[ncyc] = op;
    exp_pc[ncyc] = 3'(pc);
    exp_busy[ncyc] = busy;
    exp_done[ncyc] = done;
    exp_terr[ncyc] = terr_m;
    exp_ctr[ncyc] = ctr_m;
    if (busy) ctr_m = ctr_m | ctr[ncyc];
    ncyc++;
  endfunction
  // Expected per-cycle trace: each opcode lasts one cycle plus its stalled cycles
  function automatic void predict(int n);
    bit err = 1'b0;
    ncyc = 0;
    if (n != 0) begin
      terr_m = 1'b0;
      ctr_m = 1'b0;
    end
    for (int i = 0; i < n && !err; i++) begin
      int stalls = 0;
      forever begin
        bit st = m_store[i][5] && !cts[ncyc];
        put(m_store[i], i, 1'b1, 1'b0);
        if (!st) break;
        stalls++;
        if (TO_EN && stalls == TO) begin
          err = 1'b1;
          break;
        end
      end
    end
    if (err) begin
      terr_m = 1'b1;
      put(12'h0, 0, 1'b0, 1'b0);
    end else put(12'h0, 0, 1'b0, 1'b1);
    put(12'h0, 0, 1'b0, 1'b0);
    put(12'h0, 0, 1'b0, 1'b0);
    for (int j = 0; j < ncyc; j++)
      if (wr_en[j] && !exp_busy[j]) m_store[wr_addr[j]] = wr_data[j];
  endfunction
  always @(negedge clock)
    if (active) begin
      obs_op[cyc] = dut_op();
      obs_pc[cyc] = bus.pc;
      obs_busy[cyc] = bus.busy;
      obs_done[cyc] = bus.done;
      obs_terr[cyc] = bus.timeout_err;
      chk("trace", cyc, {16'h0, bus.busy, bus.done, bus.timeout_err, bus.ctr_seen, dut_op()},
          {16'h0, exp_busy[cyc], exp_done[cyc], exp_terr[cyc], exp_ctr[cyc], exp_op[cyc]});
      if (exp_busy[cyc]) chk("pc", cyc, 32'(bus.pc), 32'(exp_pc[cyc]));
    end
  task automatic prepare(input int p, input bit wr);
    for (int j = 0; j < MAXC; j++) begin
      cts[j] = j >= MAXC - 20 || $urandom_range(0, 99) < p;
      ctr[j] = $urandom_range(0, 3) == 0;
      wr_en[j] = wr && $urandom_range(0, 3) == 0;
      wr_addr[j] = 3'($urandom);
      wr_data[j] = 12'($urandom);
    end
  endtask
  task automatic load(input int a, input logic [11:0] d);
    @(negedge clock);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'(a);
    bus.cfg_data = d;
    @(negedge clock);
    bus.cfg_we = 1'b0;
    m_store[a] = d;
  endtask
  task automatic exec(input int n);
    predict(n);
    @(negedge clock);
    bus.go = 1'b1;
    bus.len = 4'(n);
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clock);
      #1;
      bus.go = 1'b0;
      bus.cts_i = cts[j];
      bus.ctr_i = ctr[j];
      bus.cfg_we = wr_en[j];
      bus.cfg_addr = wr_addr[j];
      bus.cfg_data = wr_data[j];
      cyc = j;
      active = 1'b1;
    end
    @(posedge clock);
    #1;
    active = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cts_i = 1'b0;
    bus.ctr_i = 1'b0;
  endtask
  function automatic int rts_count();
    int c = 0;
    for (int j = 0; j < ncyc; j++) c += int'(obs_op[j][5]);
    return c;
  endfunction
  initial begin
    logic [11:0] orig0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.len = '0;
    bus.go = 1'b0;
    bus.cts_i = 1'b0;
    bus.ctr_i = 1'b0;
    terr_m = 1'b0;
    ctr_m = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs", 0, {16'h0, bus.busy, bus.done, bus.timeout_err, bus.ctr_seen, dut_op()}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int a = 0; a < 8; a++) load(a, 12'h0);
    // basic three-opcode replay
    load(0, 12'h001);
    load(1, 12'h082);
    load(2, 12'h804);
    prepare(100, 1'b0);
    exec(3);
    chk("t1_op0", 0, 32'(obs_op[0]), 32'h001);
    chk("t1_op1", 1, 32'(obs_op[1]), 32'h082);
    chk("t1_op2", 2, 32'(obs_op[2]), 32'h804);
    chk("t1_done", 3, 32'(obs_done[3]), 32'h1);
    chk("t1_idle", 4, 32'(obs_busy[4]), 32'h0);
    // rts stalled until cts in its fourth cycle
    load(0, 12'h020);
    load(1, 12'h008);
    prepare(100, 1'b0);
    for (int j = 0; j < 3; j++) cts[j] = 1'b0;
    exec(2);
    chk("t2_rts_len", 0, 32'(rts_count()), 32'd4);
    chk("t2_pc_hold", 3, 32'(obs_pc[3]), 32'h0);
    chk("t2_start", 4, 32'(obs_op[4]), 32'h008);
    chk("t2_done", 5, 32'(obs_done[5]), 32'h1);
    if (TO_EN) begin
      prepare(100, 1'b0);
      for (int j = 0; j < 30; j++) cts[j] = 1'b0;
      exec(1);
      chk("t3_rts_len", 0, 32'(rts_count()), 32'(TO));
      chk("t3_terr", TO, 32'(obs_terr[TO]), 32'h1);
      chk("t3_err_outs", TO, {31'h0, obs_busy[TO]} | 32'(obs_op[TO]), 32'h0);
      prepare(100, 1'b0);
      for (int j = 0; j < TO - 1; j++) cts[j] = 1'b0;
      exec(2);
      chk("t3_terr_clr", 0, 32'(obs_terr[0]), 32'h0);
      chk("t3_edge_adv", TO, 32'(obs_op[TO]), 32'h008);
    end else begin
      prepare(100, 1'b0);
      for (int j = 0; j < 300; j++) cts[j] = 1'b0;
      exec(2);
      chk("t6_stall", 300, 32'(obs_op[300]), 32'h020);
      chk("t6_adv", 301, 32'(obs_op[301]), 32'h008);
      chk("t6_terr", 300, 32'(obs_terr[300]), 32'h0);
    end
    prepare(100, 1'b0);
    exec(0);
    chk("t4_done", 0, 32'(obs_done[0]), 32'h1);
    chk("t4_busy", 0, 32'(obs_busy[0]), 32'h0);
    chk("t4_op", 0, 32'(obs_op[0]), 32'h0);
    // write during a run is dropped; reset mid-run keeps the store
    for (int a = 0; a < 8; a++) load(a, 12'($urandom) & 12'hFDF);
    orig0 = m_store[0];
    @(negedge clock);
    bus.go = 1'b1;
    bus.len = 4'd8;
    @(posedge clock);
    #1;
    bus.go = 1'b0;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_data = 12'hFFF;
    @(posedge clock);
    #1;
    bus.cfg_we = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("t5_pc3", 3, 32'(bus.pc), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_outs", 3, {31'h0, bus.busy} | 32'(dut_op()), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    terr_m = 1'b0;
    ctr_m = 1'b0;
    prepare(100, 1'b0);
    exec(8);
    chk("t5_store_kept", 0, 32'(obs_op[0]), 32'(orig0));
    for (int r = 0; r < 40; r++) begin
      int n, p;
      repeat ($urandom_range(0, 3)) load($urandom_range(0, 7), 12'($urandom));
      n = $urandom_range(0, 8);
      if (terr_m && n == 0) n = 1;
      case ($urandom_range(0, 2))
        0: p = 20;
        1: p = 60;
        default: p = 100;
      endcase
      prepare(p, 1'b1);
      exec(n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
